// File: rtl/inv_final_round.sv
// AES-128 inverse final round: InvSubBytes(InvShiftRows(data_in ^ key_in)).
// One output column per cycle, built from four inverse S-box lookups.
module inv_final_round (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] t_q, t_d;
  logic [127:0] dout_q, dout_d;
  logic         out_valid_q, out_valid_d;

  // Packed byte views: FIPS byte i lives at element 15-i.
  logic [15:0][7:0] t_b;
  logic [15:0][7:0] dout_b;
  logic [1:0]       src_col;

  assign t_b = t_q;

  // Column col_cnt_q of the result; row r reads its source from column (c - r) mod 4.
  always_comb begin
    dout_b  = dout_q;
    src_col = '0;
    for (int r = 0; r < 4; r++) begin
      src_col = col_cnt_q - 2'(r);
      dout_b[4'd15 - {col_cnt_q, 2'(r)}] = inv_sbox(t_b[4'd15 - {src_col, 2'(r)}]);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    t_d         = t_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          t_d       = data_in ^ key_in;
          col_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        dout_d    = dout_b;
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      t_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      t_q         <= t_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_inv_final_round.sv
// Directed bench for inv_final_round using FIPS-197 and hand-derived vectors.
module tb_inv_final_round;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] data_out;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C1_D   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_K   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] ALL52  = {16{8'h52}};
  localparam logic [127:0] ALL63  = {16{8'h63}};
  localparam logic [127:0] ROW_K  = 128'h00630000_00000000_00000000_00000000;
  localparam logic [127:0] ROW_O  = 128'h52525252_52005252_52525252_52525252;

  inv_final_round dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .key_in   (key_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic send(input logic [127:0] d, input logic [127:0] k);
    in_valid = 1'b1;
    data_in  = d;
    key_in   = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", 128'(out_valid), 128'd0);
    chk("drain_in_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int lat;
    int nacc;
    int nout;
    int acc_i [2];
    int out_i [2];
    logic [127:0] outs [2];
    logic seen;

    // Reset values while reset is held
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with latency
    send(C1_D, C1_K);
    chk("c1_busy", 128'(busy), 128'd1);
    chk("c1_in_ready_low", 128'(in_ready), 128'd0);
    wait_out(lat);
    chk("c1_latency", 128'(lat), 128'd4);
    chk("c1_data", data_out, C1_OUT);
    drain();

    // Zero block and identical data/key
    send('0, '0);
    wait_out(lat);
    chk("zero_data", data_out, ALL52);
    drain();
    send(ALL63, ALL63);
    wait_out(lat);
    chk("same63_data", data_out, ALL52);
    drain();

    // Row 1 shift: byte 1 lands in byte 5
    send('0, ROW_K);
    wait_out(lat);
    chk("rowshift_data", data_out, ROW_O);
    drain();

    // Backpressure with a competing in_valid
    send(C1_D, C1_K);
    wait_out(lat);
    chk("bp_first", data_out, C1_OUT);
    in_valid = 1'b1;
    data_in  = '0;
    key_in   = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_data", data_out, C1_OUT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    drain();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("bp_no_extra", 128'(seen), 128'd0);

    // Back-to-back with in_valid and out_ready held high
    nacc = 0;
    nout = 0;
    acc_i = '{0, 0};
    out_i = '{0, 0};
    outs = '{'0, '0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = C1_D;
    key_in    = C1_K;
    for (int i = 0; i < 16; i++) begin
      if (nacc == 1 && !in_ready) begin
        data_in = '0;
        key_in  = ALL63;
      end
      if (nacc == 2 && !in_ready) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        if (nacc < 2) acc_i[nacc] = i;
        nacc++;
      end
      if (out_valid && out_ready) begin
        if (nout < 2) begin
          outs[nout]  = data_out;
          out_i[nout] = i;
        end
        nout++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_accepts", 128'(nacc), 128'd2);
    chk("b2b_outputs", 128'(nout), 128'd2);
    chk("b2b_interval", 128'(acc_i[1] - acc_i[0]), 128'd6);
    chk("b2b_out_timing", 128'(out_i[0] - acc_i[0]), 128'd5);
    chk("b2b_first", outs[0], C1_OUT);
    chk("b2b_second", outs[1], 128'd0);

    // Reset two cycles after accept
    send(C1_D, C1_K);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_data", data_out, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_emit", 128'(seen), 128'd0);
    send('0, ROW_K);
    wait_out(lat);
    chk("post_rst_latency", 128'(lat), 128'd4);
    chk("post_rst_data", data_out, ROW_O);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
